stream2native: RTL and testbench



---
 rtl/stream2native.sv | 79 +++++++
 tb/tb_stream2native.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream2native.sv
// AXI-Stream slave to native FIFO write-port bridge.
// A 2-entry skid buffer keeps s_axis_tready a pure register.
module stream2native #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  fifo_full,
  output logic                  fifo_wr,
  output logic [DATA_WIDTH:0]   fifo_din,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  busy
);

  localparam int W = DATA_WIDTH + 1;

  logic [1:0]   occ;
  logic [1:0]   occ_next;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [W-1:0] in_word;
  logic         tready_q;
  logic         accept;

  assign in_word       = {s_axis_tlast, s_axis_tdata};
  assign accept        = s_axis_tvalid & tready_q;
  assign s_axis_tready = tready_q;

  // Gated by rstn so a buffered word never leaks out in the reset cycle.
  assign fifo_wr  = rstn & (occ != 2'd0) & ~fifo_full;
  assign fifo_din = head;
  assign busy     = (occ != 2'd0);

  always_comb begin
    occ_next = occ + 2'(accept) - 2'(fifo_wr);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      occ      <= 2'd0;
      tready_q <= 1'b0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      occ      <= occ_next;
      tready_q <= (occ_next < 2'd2);
      if (fifo_wr) begin
        word_cnt <= word_cnt + CNT_WIDTH'(1);
        pkt_cnt  <= pkt_cnt + CNT_WIDTH'(head[DATA_WIDTH]);
      end
    end
  end

  // Storage needs no reset; occ alone says what is valid.
  always_ff @(posedge clk) begin
    unique case (occ)
      2'd0: begin
        if (accept) head <= in_word;
      end
      2'd1: begin
        if (accept && fifo_wr) head <= in_word;
        else if (accept)       tail <= in_word;
      end
      2'd2: begin
        if (fifo_wr) head <= tail;
      end
      default: begin
        head <= head;
      end
    endcase
  end

endmodule

// File: tb/tb_stream2native.sv
// Randomised bench for stream2native against a queue-based model.
// Uses CNT_WIDTH=4 throughout so counter wrap is reachable.
module tb_stream2native;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic          fifo_full;
  logic          fifo_wr;
  logic [DW:0]   fifo_din;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] pkt_cnt;
  logic          busy;

  stream2native #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rstn(rstn),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .fifo_full(fifo_full),
    .fifo_wr(fifo_wr),
    .fifo_din(fifo_din),
    .word_cnt(word_cnt),
    .pkt_cnt(pkt_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW:0] src[$];
  logic [DW:0] mq[$];
  logic [DW:0] wlog[$];
  logic [CW-1:0] wc_exp = '0;
  logic [CW-1:0] pc_exp = '0;
  logic rdy_exp = 1'b0;
  logic exp_wr;
  bit started = 1'b0;
  int full_mode = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: pending words queue; occupancy is its length.
  always @(negedge clk) begin
    if (started) begin
      exp_wr = rstn && (mq.size() != 0) && !fifo_full;
      chk("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
      chk("tready", 32'(s_axis_tready), 32'(rdy_exp));
      chk("busy", 32'(busy), 32'(mq.size() != 0));
      chk("word_cnt", 32'(word_cnt), 32'(wc_exp));
      chk("pkt_cnt", 32'(pkt_cnt), 32'(pc_exp));
      if (exp_wr && fifo_wr)
        chk("fifo_din", 32'(fifo_din), 32'(mq[0]));
      if (fifo_wr)
        wlog.push_back(fifo_din);
      if (!rstn) begin
        mq.delete();
        wc_exp = '0;
        pc_exp = '0;
        rdy_exp = 1'b0;
      end else begin
        if (exp_wr) begin
          wc_exp = wc_exp + 1'b1;
          pc_exp = pc_exp + CW'(mq[0][DW]);
          void'(mq.pop_front());
        end
        if (s_axis_tvalid && s_axis_tready)
          mq.push_back({s_axis_tlast, s_axis_tdata});
        if (mq.size() > 2) begin
          chk("occ_overflow", 32'(mq.size()), 32'd2);
          void'(mq.pop_back());
        end
        rdy_exp = (mq.size() < 2);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (full_mode)
        0: fifo_full = 1'b0;
        1: fifo_full = 1'b1;
        default: fifo_full = ~fifo_full;
      endcase
    end
  end

  task automatic set_full(input int m);
    full_mode = m;
    fifo_full = (m == 1);
  endtask

  task automatic run(input int max_cyc, input int gap, input bit must);
    int c;
    bit v;
    bit acc;
    c = 0;
    while (src.size() != 0 && c < max_cyc) begin
      v = ($urandom_range(99) >= gap);
      s_axis_tvalid = v;
      s_axis_tdata = v ? src[0][DW-1:0] : DW'($urandom);
      s_axis_tlast = v ? src[0][DW] : 1'($urandom);
      @(negedge clk);
      acc = v && s_axis_tready;
      @(posedge clk);
      #1;
      if (acc) void'(src.pop_front());
      c++;
    end
    s_axis_tvalid = 1'b0;
    if (must) chk("src_drained", 32'(src.size()), 32'd0);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      c++;
      if (c >= budget) begin
        chk("drain_timeout", 32'(busy), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    wlog.delete();
  endtask

  initial begin
    @(posedge clk);
    started = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW:0] ref_q[$];
    rstn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // 1: back-to-back stream 0x00..0x09, tlast on the last
    wlog.delete();
    set_full(0);
    for (int i = 0; i < 10; i++) src.push_back({i == 9, DW'(i)});
    run(40, 0, 1);
    drain(20);
    chk("t1_nwords", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < 10 && i < wlog.size(); i++)
      chk("t1_din", 32'(wlog[i]), (i == 9) ? 32'h109 : 32'(i));
    chk("t1_word_cnt", 32'(word_cnt), 32'd10);
    chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // 2: full backpressure then release
    do_reset();
    set_full(1);
    for (int i = 0; i < 5; i++) src.push_back({1'b0, DW'(8'hA0 + i)});
    run(8, 0, 0);
    chk("t2_accepts", 32'(5 - src.size()), 32'd2);
    @(negedge clk);
    chk("t2_tready", 32'(s_axis_tready), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_wr", 32'(fifo_wr), 32'd0);
    @(posedge clk);
    #1;
    set_full(0);
    run(40, 0, 1);
    drain(20);
    chk("t2_nwords", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      chk("t2_din", 32'(wlog[i]), 32'h0A0 + 32'(i));

    // 3: fifo_full toggling each cycle
    do_reset();
    set_full(2);
    ref_q.delete();
    for (int i = 0; i < 20; i++) begin
      src.push_back({1'($urandom), DW'($urandom)});
      ref_q.push_back(src[i]);
    end
    run(200, 0, 1);
    drain(20);
    set_full(0);
    chk("t3_nwords", 32'(wlog.size()), 32'd20);
    for (int i = 0; i < 20 && i < wlog.size(); i++)
      chk("t3_din", 32'(wlog[i]), 32'(ref_q[i]));

    // 4: packets of 1, 4, 7 words with random gaps
    do_reset();
    for (int p = 0; p < 3; p++) begin
      int len;
      len = (p == 0) ? 1 : (p == 1) ? 4 : 7;
      for (int i = 0; i < len; i++)
        src.push_back({i == len - 1, DW'($urandom)});
    end
    run(300, 50, 1);
    drain(20);
    chk("t4_nwords", 32'(wlog.size()), 32'd12);
    for (int k = 0; k < 12 && k < wlog.size(); k++)
      chk("t4_last", 32'(wlog[k][DW]), 32'(k == 0 || k == 4 || k == 11));
    chk("t4_word_cnt", 32'(word_cnt), 32'd12);
    chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd3);

    // 5: reset with two words stuck behind a full FIFO
    do_reset();
    set_full(1);
    src.push_back(9'h055);
    src.push_back(9'h056);
    run(10, 0, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_rst_wr", 32'(fifo_wr), 32'd0);
    chk("t5_rst_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_word_cnt", 32'(word_cnt), 32'd0);
    chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd0);
    @(posedge clk);
    #1;
    set_full(0);
    wlog.delete();
    src.push_back(9'h011);
    src.push_back(9'h012);
    src.push_back(9'h113);
    run(40, 0, 1);
    drain(20);
    chk("t5_nwords", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      chk("t5_din", 32'(wlog[i]), (i == 2) ? 32'h113 : 32'h011 + 32'(i));

    // 6: 4-bit counters wrap after 16 writes
    do_reset();
    for (int i = 0; i < 17; i++) src.push_back({1'b1, DW'($urandom)});
    run(80, 0, 1);
    drain(20);
    chk("t6_word_cnt", 32'(word_cnt), 32'd1);
    chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
